board_state_ctrl: RTL and testbench
===================================

// Module: board_state_ctrl
// PURPOSE
//  Owns the game board: holds the ScreenValues vector that check_for_win consumes, a cursor, and a move counter.
//  Player buttons move the cursor or toggle a cell plus its immediate neighbours (lights-out rule).
//  A scramble command randomises the board from an LFSR. Scramble never ends on a win pattern.
//  Sits directly upstream of check_for_win; buttons arrive already debounced.
// PARAMETERS
//  NumberOfBits   31   MSB index of the board; width W = NumberOfBits+1. W must be a power of 2, 8..32.
//  ScrambleSteps  20   number of LFSR-driven toggles per scramble (>=1)
// PORTS
//  clk           in   1     single system clock, all logic on rising edge
//  reset         in   1     synchronous, active-low reset
//  BtnLeft       in   1     debounced level; rising edge moves cursor toward bit 0
//  BtnRight      in   1     debounced level; rising edge moves cursor toward MSB
//  BtnToggle     in   1     debounced level; rising edge toggles cell at cursor plus neighbours
//  BtnScramble   in   1     debounced level; rising edge starts a scramble
//  ScreenValues  out  W     board state to check_for_win
//  CursorPos     out  log2W current cursor index
//  MoveCount     out  16    toggles since last scramble
//  Busy          out  1     high while scrambling
// BEHAVIOUR
//  Reset (reset==0 at clk edge): ScreenValues=0, CursorPos=0, MoveCount=0, Busy=0, state=IDLE.
//   Also on reset: lfsr=16'hACE1, button history regs=0. Reset mid-scramble aborts it immediately.
//  Edge detect: rise = Btn & ~Btn_q, with Btn_q registered every cycle.
//   The action takes effect on the same edge that samples the rise; outputs are visible after that edge.
//   Latency is 1 clk from the input going high.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle in all states except reset.
//  FSM states: IDLE, PLAY, SCRAMBLE, SETTLE.
//   IDLE: only a BtnScramble rise is honoured -> SCRAMBLE. All other buttons are ignored.
//   SCRAMBLE: Busy=1, MoveCount cleared on entry, step counter loaded with ScrambleSteps.
//    Each cycle: toggle(idx = lfsr[log2W-1:0]), decrement the counter. At 0 -> SETTLE.
//   SETTLE: Busy=1. If ScreenValues is one of the win patterns, do one more toggle(lfsr idx) and stay.
//    Otherwise -> PLAY, Busy=0.
//    Win patterns: all-0, all-1, 0101..01, 1010..10, each of width W.
//   PLAY: one action per cycle. Priority: Scramble > Toggle > Left/Right.
//    Left and Right rising together: no move.
//    Toggle together with a move: toggle at the old cursor; the move is dropped.
//  toggle(i): flip bit i, bit i-1 if i>0, and bit i+1 if i<W-1. No wrap at board edges.
//  Cursor: modulo W. Left at 0 -> W-1; Right at W-1 -> 0.
//  MoveCount: +1 per PLAY toggle, saturates at 16'hFFFF. Scramble toggles are not counted.
//  All button rises during SCRAMBLE/SETTLE are discarded; they are not queued.
//  Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Package board_pkg holds:
//   - state enum (IDLE, PLAY, SCRAMBLE, SETTLE)
//   - LFSR_SEED 16'hACE1 and tap mask
//   - win-pattern constants (all-0, all-1, 0101.., 1010..), shared with check_for_win so both blocks agree.
//  One sub-module: lfsr16 (clk, reset, output [15:0] value); the rest stays inline.
// TESTING
//  1. Reset low 2 clks -> ScreenValues=0, CursorPos=0, MoveCount=0, Busy=0. Buttons pressed in IDLE change nothing.
//  2. W=32, from IDLE raise BtnScramble -> Busy=1 for >=20 clks.
//     Then Busy=0, state PLAY, ScreenValues not in win set, MoveCount=0.
//  3. Force board 0 via reset+scramble model, cursor=0, BtnToggle rise -> bits 0,1 flip (32'h00000003 xor prior).
//     Cursor=31 toggle flips bits 31,30 only. Cursor=5 flips bits 4,5,6.
//  4. CursorPos=0, BtnLeft rise -> 31; BtnRight rise -> 0.
//     Left+Right same cycle -> unchanged. Toggle+Right same cycle -> toggle at old idx, cursor unchanged.
//  5. Hold BtnToggle high 10 clks -> exactly one toggle, MoveCount+1.
//     Preload MoveCount to 16'hFFFF via 65535 toggles -> next toggle keeps 16'hFFFF.
//  6. Assert reset mid-SCRAMBLE (step 7) -> next cycle all outputs at reset values.
//     LFSR reseeded, so an identical scramble sequence reproduces an identical board.

Source files
------------

// File: rtl/board_state_ctrl_pkg.sv
// board_pkg: shared board types, LFSR constants and win patterns (rev 1.0)
// Win constants are shared with check_for_win so both blocks agree on what counts as a win.
`default_nettype none
package board_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PLAY     = 2'd1,
      SCRAMBLE = 2'd2,
      SETTLE   = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [31:0] WIN_ZEROS = 32'h0000_0000;
   localparam logic [31:0] WIN_ONES  = 32'hFFFF_FFFF;
   localparam logic [31:0] WIN_ALT01 = 32'h5555_5555;
   localparam logic [31:0] WIN_ALT10 = 32'hAAAA_AAAA;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_state_ctrl_if.sv
// board_state_ctrl_if: button inputs and board outputs between the player front end and the board (rev 1.0)
`default_nettype none
interface board_state_ctrl_if #(
   parameter int W  = 32,
   parameter int CW = 5
);
   logic          BtnLeft;
   logic          BtnRight;
   logic          BtnToggle;
   logic          BtnScramble;
   logic [W-1:0]  ScreenValues;
   logic [CW-1:0] CursorPos;
   logic [15:0]   MoveCount;
   logic          Busy;

   modport master (
      output BtnLeft, BtnRight, BtnToggle, BtnScramble,
      input  ScreenValues, CursorPos, MoveCount, Busy
   );

   modport slave (
      input  BtnLeft, BtnRight, BtnToggle, BtnScramble,
      output ScreenValues, CursorPos, MoveCount, Busy
   );
endinterface
`default_nettype wire

// File: rtl/board_state_ctrl_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, reseeded on synchronous active-low reset (rev 1.0)
`default_nettype none
module lfsr16
   import board_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        reset,
   output logic [15:0]      value
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         value <= LFSR_SEED;
      end else begin
         value <= lfsr_next(value);
      end
   end

endmodule
`default_nettype wire

// File: rtl/board_state_ctrl.sv
// board_state_ctrl: lights-out board, cursor and move counter with LFSR scramble (rev 1.0)
`default_nettype none
module board_state_ctrl
   import board_pkg::*;
#(
   parameter int NumberOfBits  = 31,
   parameter int ScrambleSteps = 20
)(
   input  wire logic          clk,
   input  wire logic          reset,
   board_state_ctrl_if.slave  bus
);

   localparam int W  = NumberOfBits + 1;
   localparam int CW = $clog2(W);
   localparam int SW = $clog2(ScrambleSteps + 1);

   localparam logic [W-1:0] C_WIN_ZEROS = WIN_ZEROS[W-1:0];
   localparam logic [W-1:0] C_WIN_ONES  = WIN_ONES[W-1:0];
   localparam logic [W-1:0] C_WIN_ALT01 = WIN_ALT01[W-1:0];
   localparam logic [W-1:0] C_WIN_ALT10 = WIN_ALT10[W-1:0];

   logic [15:0]   w_lfsr;
   logic [3:0]    w_btn;
   logic [3:0]    w_rise;
   logic [CW-1:0] w_lfsr_idx;
   logic          w_win;

   logic [3:0]    r_btn_q;
   logic [W-1:0]  r_board;
   logic [CW-1:0] r_cursor;
   logic [15:0]   r_move_count;
   logic          r_busy;
   logic [SW-1:0] r_steps;
   state_t        r_state;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .value (w_lfsr)
   );

   // Bit order {scramble, toggle, right, left}
   assign w_btn      = {bus.BtnScramble, bus.BtnToggle, bus.BtnRight, bus.BtnLeft};
   assign w_rise     = w_btn & ~r_btn_q;
   assign w_lfsr_idx = CW'(w_lfsr);
   assign w_win      = (r_board == C_WIN_ZEROS) || (r_board == C_WIN_ONES) ||
                       (r_board == C_WIN_ALT01) || (r_board == C_WIN_ALT10);

   // 3'b111 shifted up by idx then down by one lands on idx-1..idx+1; the ends fall off the board
   function automatic logic [W-1:0] toggle_mask(input logic [CW-1:0] idx);
      logic [W+1:0] m;
      m = (W+2)'(7) << idx;
      return W'(m >> 1);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_btn_q      <= '0;
         r_board      <= '0;
         r_cursor     <= '0;
         r_move_count <= '0;
         r_busy       <= 1'b0;
         r_steps      <= '0;
         r_state      <= IDLE;
      end else begin
         r_btn_q <= w_btn;
         if ((r_state == IDLE || r_state == PLAY) && w_rise[3]) begin
            r_state      <= SCRAMBLE;
            r_busy       <= 1'b1;
            r_move_count <= '0;
            r_steps      <= SW'(ScrambleSteps);
         end else begin
            case (r_state)
               PLAY: begin
                  if (w_rise[2]) begin
                     r_board <= r_board ^ toggle_mask(r_cursor);
                     if (r_move_count != 16'hFFFF) begin
                        r_move_count <= r_move_count + 16'd1;
                     end
                  end else if (w_rise[0] && !w_rise[1]) begin
                     r_cursor <= r_cursor - CW'(1);
                  end else if (w_rise[1] && !w_rise[0]) begin
                     r_cursor <= r_cursor + CW'(1);
                  end
               end
               SCRAMBLE: begin
                  r_board <= r_board ^ toggle_mask(w_lfsr_idx);
                  r_steps <= r_steps - SW'(1);
                  if (r_steps == SW'(1)) begin
                     r_state <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (w_win) begin
                     r_board <= r_board ^ toggle_mask(w_lfsr_idx);
                  end else begin
                     r_state <= PLAY;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   assign bus.ScreenValues = r_board;
   assign bus.CursorPos    = r_cursor;
   assign bus.MoveCount    = r_move_count;
   assign bus.Busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: randomized self-checking bench for board_state_ctrl with a behavioural board model (rev 1.0)
`default_nettype none
module tb_board_state_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   board_state_ctrl_if #(.W(32), .CW(5)) bus();

   board_state_ctrl #(
      .NumberOfBits  (31),
      .ScrambleSteps (20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_lfsr;
   logic [31:0] m_board;
   int          m_cursor;
   logic [15:0] m_moves;
   logic [31:0] saved_board;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [31:0] tmask(input int i);
      logic [31:0] m;
      m = 32'h0;
      m[i] = 1'b1;
      if (i > 0)  m[i-1] = 1'b1;
      if (i < 31) m[i+1] = 1'b1;
      return m;
   endfunction

   function automatic bit is_win(input logic [31:0] b);
      return (b == 32'h0) || (b == 32'hFFFF_FFFF) || (b == 32'h5555_5555) || (b == 32'hAAAA_AAAA);
   endfunction

   // Independent LFSR reference, reseeded exactly when the DUT is
   always @(posedge clk) begin
      if (!reset) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic set_btns(input logic [3:0] b);
      {bus.BtnScramble, bus.BtnToggle, bus.BtnRight, bus.BtnLeft} = b;
   endtask

   task automatic press(input logic [3:0] b);
      set_btns(b);
      @(negedge clk);
      set_btns(4'b0000);
      @(negedge clk);
   endtask

   task automatic model_play(input logic [3:0] b);
      if (b[2]) begin
         m_board = m_board ^ tmask(m_cursor);
         if (m_moves != 16'hFFFF) m_moves = m_moves + 16'd1;
      end else if (b[0] && !b[1]) begin
         m_cursor = (m_cursor + 31) % 32;
      end else if (b[1] && !b[0]) begin
         m_cursor = (m_cursor + 1) % 32;
      end
   endtask

   task automatic do_reset();
      set_btns(4'b0000);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_board  = 32'h0;
      m_cursor = 0;
      m_moves  = 16'h0;
   endtask

   task automatic test_reset();
      set_btns(4'b0000);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.ScreenValues !== 32'h0 || bus.CursorPos !== 5'd0 || bus.MoveCount !== 16'h0 || bus.Busy !== 1'b0) begin
         failures++;
         $display("FAIL reset: got board=%h cur=%0d moves=%h busy=%b want all zero",
                  bus.ScreenValues, bus.CursorPos, bus.MoveCount, bus.Busy);
      end
      reset = 1'b1;
      m_board = 32'h0; m_cursor = 0; m_moves = 16'h0;
   endtask

   task automatic test_idle_ignore();
      press(4'b0100);
      press(4'b0001);
      press(4'b0010);
      press(4'b0111);
      checks++;
      if (bus.ScreenValues !== 32'h0 || bus.CursorPos !== 5'd0 || bus.MoveCount !== 16'h0 || bus.Busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_ignore: got board=%h cur=%0d moves=%h busy=%b want all zero",
                  bus.ScreenValues, bus.CursorPos, bus.MoveCount, bus.Busy);
      end
   endtask

   // Starts a scramble at the current negedge and follows it to completion against the model
   task automatic do_scramble(input bit with_tog, input string name);
      logic [15:0] l;
      logic [31:0] b;
      int extra;
      int cnt;
      l = lfsr_step(m_lfsr);
      b = m_board;
      for (int s = 0; s < 20; s++) begin
         b = b ^ tmask(int'(l[4:0]));
         l = lfsr_step(l);
      end
      extra = 0;
      while (is_win(b) && extra < 100) begin
         b = b ^ tmask(int'(l[4:0]));
         l = lfsr_step(l);
         extra++;
      end
      set_btns({1'b1, with_tog, 2'b00});
      @(negedge clk);
      set_btns(4'b0000);
      cnt = 0;
      while (bus.Busy === 1'b1 && cnt < 200) begin
         cnt++;
         if (cnt == 5) set_btns(4'b0101);
         if (cnt == 6) set_btns(4'b0000);
         @(negedge clk);
      end
      checks++;
      if (cnt != 21 + extra) begin
         failures++;
         $display("FAIL %s busy_len: got %0d cycles want %0d", name, cnt, 21 + extra);
      end
      checks++;
      if (bus.ScreenValues !== b) begin
         failures++;
         $display("FAIL %s board: got %h want %h", name, bus.ScreenValues, b);
      end
      checks++;
      if (is_win(bus.ScreenValues) || bus.MoveCount !== 16'h0 || bus.CursorPos !== 5'(m_cursor) || bus.Busy !== 1'b0) begin
         failures++;
         $display("FAIL %s post: got board=%h moves=%h cur=%0d busy=%b want non-win, 0, %0d, 0",
                  name, bus.ScreenValues, bus.MoveCount, bus.CursorPos, bus.Busy, m_cursor);
      end
      m_board = b;
      m_moves = 16'h0;
   endtask

   task automatic test_toggle_edges();
      logic [31:0] prior;
      prior = m_board;
      press(4'b0100); model_play(4'b0100);
      checks++;
      if (bus.ScreenValues !== (prior ^ 32'h0000_0003)) begin
         failures++;
         $display("FAIL toggle_idx0: got %h want %h", bus.ScreenValues, prior ^ 32'h0000_0003);
      end
      press(4'b0001); model_play(4'b0001);
      prior = m_board;
      press(4'b0100); model_play(4'b0100);
      checks++;
      if (bus.ScreenValues !== (prior ^ 32'hC000_0000) || bus.CursorPos !== 5'd31) begin
         failures++;
         $display("FAIL toggle_idx31: got %h cur=%0d want %h cur=31", bus.ScreenValues, bus.CursorPos, prior ^ 32'hC000_0000);
      end
      repeat (6) begin press(4'b0010); model_play(4'b0010); end
      prior = m_board;
      press(4'b0100); model_play(4'b0100);
      checks++;
      if (bus.ScreenValues !== (prior ^ 32'h0000_0070) || bus.CursorPos !== 5'd5) begin
         failures++;
         $display("FAIL toggle_idx5: got %h cur=%0d want %h cur=5", bus.ScreenValues, bus.CursorPos, prior ^ 32'h0000_0070);
      end
      checks++;
      if (bus.MoveCount !== 16'd3) begin
         failures++;
         $display("FAIL toggle_count: got %0d want 3", bus.MoveCount);
      end
   endtask

   task automatic test_cursor();
      while (m_cursor != 0) begin press(4'b0010); model_play(4'b0010); end
      press(4'b0001); model_play(4'b0001);
      checks++;
      if (bus.CursorPos !== 5'd31) begin
         failures++;
         $display("FAIL cursor_wrap_left: got %0d want 31", bus.CursorPos);
      end
      press(4'b0010); model_play(4'b0010);
      checks++;
      if (bus.CursorPos !== 5'd0) begin
         failures++;
         $display("FAIL cursor_wrap_right: got %0d want 0", bus.CursorPos);
      end
      press(4'b0011); model_play(4'b0011);
      checks++;
      if (bus.CursorPos !== 5'd0 || bus.ScreenValues !== m_board) begin
         failures++;
         $display("FAIL cursor_left_right: got cur=%0d board=%h want cur=0 board=%h", bus.CursorPos, bus.ScreenValues, m_board);
      end
      press(4'b0110); model_play(4'b0110);
      checks++;
      if (bus.CursorPos !== 5'd0 || bus.ScreenValues !== m_board || bus.MoveCount !== m_moves) begin
         failures++;
         $display("FAIL toggle_with_right: got cur=%0d board=%h moves=%h want cur=0 board=%h moves=%h",
                  bus.CursorPos, bus.ScreenValues, bus.MoveCount, m_board, m_moves);
      end
   endtask

   task automatic test_hold_toggle();
      set_btns(4'b0100);
      repeat (10) @(negedge clk);
      set_btns(4'b0000);
      @(negedge clk);
      model_play(4'b0100);
      checks++;
      if (bus.ScreenValues !== m_board || bus.MoveCount !== m_moves) begin
         failures++;
         $display("FAIL hold_toggle: got board=%h moves=%h want board=%h moves=%h",
                  bus.ScreenValues, bus.MoveCount, m_board, m_moves);
      end
   endtask

   task automatic test_random_play();
      logic [3:0] b;
      for (int i = 0; i < 40; i++) begin
         b = {1'b0, 3'($urandom_range(1, 7))};
         press(b);
         model_play(b);
         checks++;
         if (bus.ScreenValues !== m_board || bus.CursorPos !== 5'(m_cursor) || bus.MoveCount !== m_moves) begin
            failures++;
            $display("FAIL random_play[%0d] btn=%b: got board=%h cur=%0d moves=%h want board=%h cur=%0d moves=%h",
                     i, b, bus.ScreenValues, bus.CursorPos, bus.MoveCount, m_board, m_cursor, m_moves);
         end
      end
   endtask

   task automatic test_saturation();
      force dut.r_move_count = 16'hFFFE;
      @(negedge clk);
      release dut.r_move_count;
      m_moves = 16'hFFFE;
      press(4'b0100); model_play(4'b0100);
      checks++;
      if (bus.MoveCount !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_reach: got %h want ffff", bus.MoveCount);
      end
      press(4'b0100); model_play(4'b0100);
      checks++;
      if (bus.MoveCount !== 16'hFFFF || bus.ScreenValues !== m_board) begin
         failures++;
         $display("FAIL sat_hold: got moves=%h board=%h want ffff board=%h", bus.MoveCount, bus.ScreenValues, m_board);
      end
   endtask

   task automatic test_reset_mid_scramble();
      do_reset();
      repeat (3) @(negedge clk);
      do_scramble(1'b0, "reseed_ref");
      saved_board = m_board;
      set_btns(4'b0000);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      set_btns(4'b1000);
      @(negedge clk);
      set_btns(4'b0000);
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ScreenValues !== 32'h0 || bus.CursorPos !== 5'd0 || bus.MoveCount !== 16'h0 || bus.Busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_scramble: got board=%h cur=%0d moves=%h busy=%b want all zero",
                  bus.ScreenValues, bus.CursorPos, bus.MoveCount, bus.Busy);
      end
      @(negedge clk);
      reset = 1'b1;
      m_board = 32'h0; m_cursor = 0; m_moves = 16'h0;
      repeat (3) @(negedge clk);
      do_scramble(1'b0, "reseed_repeat");
      checks++;
      if (bus.ScreenValues !== saved_board) begin
         failures++;
         $display("FAIL reseed_identical: got %h want %h", bus.ScreenValues, saved_board);
      end
   endtask

   initial begin
      set_btns(4'b0000);
      @(negedge clk);
      test_reset();
      test_idle_ignore();
      do_scramble(1'b0, "scramble_idle");
      test_toggle_edges();
      test_cursor();
      test_hold_toggle();
      test_random_play();
      do_scramble(1'b1, "scramble_play_prio");
      test_random_play();
      test_saturation();
      test_reset_mid_scramble();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
